// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the 16-bit core front end.
//   CPU_ADDR_W / CPU_INSTR_W : default address and instruction widths
//   OPC_HLT                  : opcode (instr[15:12]) of the halt instruction
//   PC_STEP                  : byte increment between sequential fetches
//   fetch_state_t            : fetch-control FSM states
package cpu_pkg;

  localparam int         CPU_ADDR_W  = 16;
  localparam int         CPU_INSTR_W = 16;
  localparam logic [3:0] OPC_HLT     = 4'hF;
  localparam int         PC_STEP     = 2;

  typedef enum logic {
    FETCH   = 1'b0,
    STOPPED = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry circular buffer of W-bit words.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : empties the queue; takes priority over push and pop
//   push        : write push_data at the tail (ignored when full without a pop)
//   pop         : drop the head entry (ignored when empty)
//   head_data   : current head entry, meaningful only while count != 0
//   count       : number of valid entries
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module fetch_queue #(
  parameter  int W     = 32,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     head_data,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full queue can still take a push in the cycle its head leaves.
  assign do_push = push && (!full || do_pop);

  // NOTE: non-blocking assignments here so every register sees pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; an entry is only read once count says it holds data.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: instruction-fetch stage with a DEPTH-entry prefetch queue.
//   clk, rst_n                     : clock, asynchronous active-low reset
//   imem_req_valid/ready/addr      : in-order fetch requests to instruction memory
//   imem_rsp_valid/data            : in-order responses (never back-pressured)
//   instr_valid/ready, instr, instr_pc : queue head handed to decode
//   redirect_valid, redirect_pc    : flush queued and in-flight fetches, restart at redirect_pc
//   halt_i                         : level, stops new requests
//   fetch_stopped                  : FSM is in STOPPED
// Build option: define FETCH_HLT_DETECT_EN to stop fetching once an OPC_HLT instruction
// is queued; fetch then resumes only on redirect_valid.
module fetch_prefetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = CPU_ADDR_W,
  parameter int                INSTR_W  = CPU_INSTR_W,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt_i,
  output logic               fetch_stopped
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = ADDR_W + INSTR_W;

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic [CNT_W-1:0]  q_count;
  logic [CNT_W:0]    in_use;
  logic [ENT_W-1:0]  q_head;
  logic              credit_ok;
  logic              req_fire;
  logic              rsp_ret;
  logic              rsp_keep;
  logic              hlt_seen;
  logic              hlt_stop;

  // PCs of live (not-to-be-dropped) requests, written when the request is accepted.
  logic [ADDR_W-1:0] tag_mem [DEPTH];
  logic [PTR_W-1:0]  tag_wr_ptr;
  logic [PTR_W-1:0]  tag_rd_ptr;

  // Queued plus in-flight entries may never exceed the queue size, so every
  // response has a free slot waiting for it.
  assign in_use    = {1'b0, q_count} + {1'b0, outstanding_q};
  assign credit_ok = in_use < (CNT_W + 1)'(DEPTH);

  // rst_n gates the request so nothing is offered while reset is held.
  assign imem_req_valid = rst_n && (state_q == FETCH) && credit_ok && !redirect_valid;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response only counts against an outstanding request; anything arriving
  // during a redirect or while stale requests remain is discarded.
  assign rsp_ret  = imem_rsp_valid && (outstanding_q != '0);
  assign rsp_keep = rsp_ret && (drop_q == '0) && !redirect_valid;

`ifdef FETCH_HLT_DETECT_EN
  assign hlt_seen = rsp_keep && (imem_rsp_data[INSTR_W-1 -: 4] == OPC_HLT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              hlt_stop <= 1'b0;
    else if (redirect_valid) hlt_stop <= 1'b0;
    else if (hlt_seen)       hlt_stop <= 1'b1;
  end
`else
  assign hlt_seen = 1'b0;
  assign hlt_stop = 1'b0;
`endif

  // NOTE: every variable of this block is given a default first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;

    if (req_fire && !rsp_ret)      outstanding_d = outstanding_q + CNT_W'(1);
    else if (!req_fire && rsp_ret) outstanding_d = outstanding_q - CNT_W'(1);

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~ADDR_W'(1);
      // Everything still in flight after this cycle belongs to the old stream.
      drop_d     = outstanding_d;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
      if (rsp_ret && (drop_q != '0)) drop_d = drop_q - CNT_W'(1);
    end

    case (state_q)
      FETCH: begin
        if (halt_i || hlt_seen) state_d = STOPPED;
      end
      STOPPED: begin
        if (redirect_valid || (!halt_i && !hlt_stop)) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FETCH;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      tag_wr_ptr    <= '0;
      tag_rd_ptr    <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      if (redirect_valid) begin
        tag_wr_ptr <= '0;
        tag_rd_ptr <= '0;
      end else begin
        if (req_fire) tag_wr_ptr <= tag_wr_ptr + PTR_W'(1);
        if (rsp_keep) tag_rd_ptr <= tag_rd_ptr + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) tag_mem[tag_wr_ptr] <= fetch_pc_q;
  end

  fetch_queue #(
    .W     (ENT_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (redirect_valid),
    .push      (rsp_keep),
    .push_data ({tag_mem[tag_rd_ptr], imem_rsp_data}),
    .pop       (instr_valid && instr_ready),
    .head_data (q_head),
    .count     (q_count)
  );

  // Outputs are forced to zero while the queue is empty so stale storage never leaks out.
  assign instr_valid   = (q_count != '0);
  assign instr         = instr_valid ? q_head[INSTR_W-1:0]     : '0;
  assign instr_pc      = instr_valid ? q_head[ENT_W-1:INSTR_W] : '0;
  assign fetch_stopped = (state_q == STOPPED);

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb_fetch_prefetch_unit: directed bench for fetch_prefetch_unit with a
// variable-latency in-order instruction memory model. Inputs change 1 time
// unit after the rising edge; outputs are sampled on the falling edge.
// Cycle 1 of each test is the first cycle after rst_n deasserts.
module tb_fetch_prefetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [15:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [15:0] imem_rsp_data = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        halt_i = 1'b0;
  logic        fetch_stopped;

  int n_checks = 0;
  int n_errors = 0;

  int mem_lat     = 1;
  bit hlt_word_en = 1'b0;
  int cyc         = 0;

  typedef struct {
    int          due;
    logic [15:0] addr;
  } pend_t;

  pend_t       pend[$];
  logic [15:0] req_log[$];

  always #5 clk = ~clk;

  fetch_prefetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_i         (halt_i),
    .fetch_stopped  (fetch_stopped)
  );

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (hlt_word_en && a == 16'h0006) return 16'hF000;
    return {4'h1, a[11:0]};
  endfunction

  // Memory model: a request accepted in cycle c answers in cycle c + mem_lat.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend.delete();
      end else if (imem_req_valid && imem_req_ready) begin
        pend.push_back('{due: cyc + mem_lat, addr: imem_req_addr});
        req_log.push_back(imem_req_addr);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (rst_n && pend.size() > 0 && pend[0].due == cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic expect_head(input string tag, input logic [15:0] pc);
    check({tag, "_valid"}, instr_valid, 1);
    check({tag, "_pc"}, instr_pc, pc);
    check({tag, "_instr"}, instr, mem_word(pc));
  endtask

  task automatic expect_req(input string tag, input logic [15:0] addr);
    check({tag, "_req_valid"}, imem_req_valid, 1);
    check({tag, "_req_addr"}, imem_req_addr, addr);
  endtask

  task automatic check_log(input string tag, input int idx, input logic [15:0] addr);
    logic [31:0] got;
    got = (idx < req_log.size()) ? {16'h0, req_log[idx]} : 32'hDEAD_BEEF;
    check(tag, got, {16'h0, addr});
  endtask

  // Holds reset for two edges, checks the reset state, and returns at the start of cycle 1.
  task automatic do_reset(input int lat);
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halt_i         = 1'b0;
    instr_ready    = 1'b0;
    imem_req_ready = 1'b1;
    mem_lat        = lat;
    hlt_word_en    = 1'b0;
    tick();
    mid();
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_req_addr", imem_req_addr, 16'h0000);
    check("rst_instr_valid", instr_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_instr_pc", instr_pc, 0);
    check("rst_stopped", fetch_stopped, 0);
    tick();
    req_log.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: streaming from reset with a 1-cycle memory.
    do_reset(1);
    instr_ready = 1'b1;
    mid(); expect_req("t1_c1", 16'h0000); check("t1_c1_ivalid", instr_valid, 0);
    tick(); mid(); expect_req("t1_c2", 16'h0002); check("t1_c2_ivalid", instr_valid, 0);
    tick(); mid(); expect_head("t1_c3", 16'h0000);
    tick(); mid(); expect_head("t1_c4", 16'h0002);
    tick(); mid(); expect_head("t1_c5", 16'h0004);
    for (int i = 0; i < 4; i++) check_log($sformatf("t1_log%0d", i), i, 16'(2 * i));

    // 2: decode stalled -> exactly DEPTH requests, then one pop frees one slot.
    do_reset(1);
    repeat (9) tick();
    mid();
    check("t2_c10_req_valid", imem_req_valid, 0);
    check("t2_c10_nreq", req_log.size(), 4);
    expect_head("t2_c10", 16'h0000);
    tick(); instr_ready = 1'b1;
    mid(); check("t2_c11_req_valid", imem_req_valid, 0);
    tick(); instr_ready = 1'b0;
    mid(); expect_req("t2_c12", 16'h0008); expect_head("t2_c12", 16'h0002);

    // 3: 3-cycle memory, redirect with two requests in flight.
    do_reset(3);
    mid(); expect_req("t3_c1", 16'h0000);
    tick(); mid(); expect_req("t3_c2", 16'h0002);
    tick(); redirect_valid = 1'b1; redirect_pc = 16'h0040;
    mid(); check("t3_c3_req_valid", imem_req_valid, 0);
    tick(); redirect_valid = 1'b0;
    mid(); expect_req("t3_c4", 16'h0040); check("t3_c4_ivalid", instr_valid, 0);
    tick(); mid(); check("t3_c5_ivalid", instr_valid, 0);
    tick(); mid(); check("t3_c6_ivalid", instr_valid, 0);
    tick(); mid(); check("t3_c7_ivalid", instr_valid, 0);
    tick(); mid(); expect_head("t3_c8", 16'h0040);
    check_log("t3_log3", 3, 16'h0042);

    // 4: redirect, pop and response in the same cycle; redirect_pc bit 0 is ignored.
    do_reset(1);
    mid(); expect_req("t4_c1", 16'h0000);
    tick(); mid(); expect_req("t4_c2", 16'h0002);
    tick(); redirect_valid = 1'b1; redirect_pc = 16'h0081; instr_ready = 1'b1;
    mid(); expect_head("t4_c3", 16'h0000); check("t4_c3_req_valid", imem_req_valid, 0);
    tick(); redirect_valid = 1'b0; instr_ready = 1'b0;
    mid(); check("t4_c4_ivalid", instr_valid, 0); expect_req("t4_c4", 16'h0080);
    tick(); mid(); check("t4_c5_ivalid", instr_valid, 0);
    tick(); mid(); expect_head("t4_c6", 16'h0080);

    // 5: redirect near the top of the address space, PC wraps to zero.
    do_reset(1);
    instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'hFFFC;
    mid(); check("t5_c1_req_valid", imem_req_valid, 0);
    tick(); redirect_valid = 1'b0;
    mid(); expect_req("t5_c2", 16'hFFFC);
    tick(); mid(); expect_req("t5_c3", 16'hFFFE);
    tick(); mid(); expect_req("t5_c4", 16'h0000); expect_head("t5_c4", 16'hFFFC);
    tick(); mid(); expect_head("t5_c5", 16'hFFFE);
    tick(); mid(); expect_head("t5_c6", 16'h0000);
    // Reset asserted mid-stream clears state immediately.
    tick(); rst_n = 1'b0;
    #1;
    check("t5_arst_ivalid", instr_valid, 0);
    check("t5_arst_req_valid", imem_req_valid, 0);
    check("t5_arst_req_addr", imem_req_addr, 16'h0000);

    // halt_i: stop after the request in flight, drain it, resume when halt_i drops.
    do_reset(1);
    instr_ready = 1'b1; halt_i = 1'b1;
    mid(); expect_req("th_c1", 16'h0000); check("th_c1_stopped", fetch_stopped, 0);
    tick(); mid(); check("th_c2_stopped", fetch_stopped, 1); check("th_c2_req_valid", imem_req_valid, 0);
    tick(); mid(); expect_head("th_c3", 16'h0000); check("th_c3_stopped", fetch_stopped, 1);
    tick(); halt_i = 1'b0;
    mid(); check("th_c4_stopped", fetch_stopped, 1); check("th_c4_req_valid", imem_req_valid, 0);
    tick(); mid(); check("th_c5_stopped", fetch_stopped, 0); expect_req("th_c5", 16'h0002);

    // 6: HLT word (0xF000) returned for pc 0x0006.
    do_reset(1);
    instr_ready = 1'b1; hlt_word_en = 1'b1;
    repeat (4) tick();
    mid(); expect_req("t6_c5", 16'h0008);
    tick(); mid();
    expect_head("t6_c6", 16'h0006);
`ifdef FETCH_HLT_DETECT_EN
    check("t6_c6_stopped", fetch_stopped, 1);
    check("t6_c6_req_valid", imem_req_valid, 0);
    tick(); mid(); expect_head("t6_c7", 16'h0008);
    tick(); tick(); mid();
    check("t6_c9_stopped", fetch_stopped, 1);
    check("t6_c9_req_valid", imem_req_valid, 0);
    check("t6_c9_nreq", req_log.size(), 5);
    tick(); redirect_valid = 1'b1; redirect_pc = 16'h0100;
    mid(); check("t6_c10_stopped", fetch_stopped, 1);
    tick(); redirect_valid = 1'b0;
    mid(); check("t6_c11_stopped", fetch_stopped, 0); expect_req("t6_c11", 16'h0100);
`else
    check("t6_c6_stopped", fetch_stopped, 0);
    expect_req("t6_c6", 16'h000A);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
